// File: rtl/exe_muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the EXE-stage multiply/divide unit:
//   - operation encodings carried on exe_op
//   - FSM state encoding (IDLE / CALC / SIGN)
//   - default operand width
//   - small decode helpers for the op field
// Optional feature macro used by the unit: MDU_DIV_EN (divider datapath).
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } mdu_state_e;

    // Bit 0 clear selects the signed flavour of both mult and div.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/exe_muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// exe_muldiv_unit_if
// Bundles the ID/EXE -> multiply/divide unit request and the unit's
// stall/result signals.
//   master : pipeline side (drives start/op/operands/cancel, sees stall/results)
//   slave  : multiply/divide unit side
// Signals:
//   exe_start  EXE holds a mult/div instruction
//   exe_op     00 mult, 01 multu, 10 div, 11 divu
//   exe_ra     multiplicand / dividend
//   exe_rb     multiplier / divisor
//   exe_cancel synchronous flush of the EXE instruction
//   mdu_stall  freezes PC, IF/ID and ID/EXE
//   mdu_done   one-cycle completion pulse
//   mdu_hi     product high word / remainder
//   mdu_lo     product low word / quotient
// -----------------------------------------------------------------------------
interface exe_muldiv_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) ();

    logic             exe_start;
    logic [1:0]       exe_op;
    logic [WIDTH-1:0] exe_ra;
    logic [WIDTH-1:0] exe_rb;
    logic             exe_cancel;
    logic             mdu_stall;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_hi;
    logic [WIDTH-1:0] mdu_lo;

    modport master (
        output exe_start, exe_op, exe_ra, exe_rb, exe_cancel,
        input  mdu_stall, mdu_done, mdu_hi, mdu_lo
    );

    modport slave (
        input  exe_start, exe_op, exe_ra, exe_rb, exe_cancel,
        output mdu_stall, mdu_done, mdu_hi, mdu_lo
    );

endinterface

// File: rtl/exe_muldiv_unit_iter_step.sv
// -----------------------------------------------------------------------------
// mdu_iter_step
// Combinational single iteration of the multiply/divide loop.
//   partial_i  {hi, lo} working register (2*WIDTH)
//   operand_i  multiplicand (mult) or divisor (div)
//   op_i       operation; bit 1 selects divide
//   partial_o  working register after one iteration
// Multiply: shift-add, multiplier consumed from the LSB of lo, product
//           shifts in from the top.
// Divide:   restoring division, dividend shifts out of the MSB of lo into
//           the remainder, quotient bits shift into the LSB of lo.
// The divide path exists only when MDU_DIV_EN is defined.
// -----------------------------------------------------------------------------
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH-1:0] partial_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic [1:0]         op_i,
    output logic [2*WIDTH-1:0] partial_o
);

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    // Carry out of the add lands in the MSB after the right shift.
    assign mul_sum  = {1'b0, partial_i[2*WIDTH-1:WIDTH]}
                    + (partial_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, partial_i[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_trial;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_next;

    // Remainder is always below the divisor, so the shifted value needs
    // only one extra bit and the restored result fits back into WIDTH bits.
    assign rem_shift = {partial_i[2*WIDTH-1:WIDTH], partial_i[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, operand_i});
    assign rem_trial = rem_shift - {1'b0, operand_i};
    assign div_next  = {rem_ge ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0],
                        partial_i[WIDTH-2:0], rem_ge};

    assign partial_o = op_is_div(op_i) ? div_next : mul_next;
`else
    logic unused_op;
    assign unused_op = ^op_i;
    assign partial_o = mul_next;
`endif

endmodule

// File: rtl/exe_muldiv_unit.sv
// -----------------------------------------------------------------------------
// exe_muldiv_unit
// Multi-cycle multiply/divide unit in the EXE stage. One iteration per clock
// (WIDTH iterations), followed by a sign-correction cycle that writes HI/LO
// and pulses mdu_done. Stalls the front of the pipeline while busy.
// Ports:
//   clk   pipeline clock, rising edge
//   clrn  asynchronous active-low reset
//   bus   exe_muldiv_unit_if.slave (start/op/operands/cancel in,
//         stall/done/hi/lo out)
// Build option: define MDU_DIV_EN to include the divider; without it,
// divide ops are ignored (no start, no stall, no done, HI/LO untouched).
// -----------------------------------------------------------------------------
module exe_muldiv_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic                clk,
    input  logic                clrn,
    exe_muldiv_unit_if.slave    bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e         state_q,   state_d;
    logic [1:0]         op_q,      op_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic               neg_lo_q,  neg_lo_d;   // negate product / quotient
    logic               neg_hi_q,  neg_hi_d;   // negate remainder
    logic               dz_q,      dz_d;       // divisor was zero
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               done_q,    done_d;

    logic               op_allowed;
    logic               start_ok;
    logic               ra_neg, rb_neg;
    logic [WIDTH-1:0]   abs_ra, abs_rb;
    logic [2*WIDTH-1:0] step_partial;
    logic [2*WIDTH-1:0] mul_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MDU_DIV_EN
    assign op_allowed = 1'b1;
`else
    assign op_allowed = ~op_is_div(bus.exe_op);
`endif

    // Start is refused during the done cycle: that instruction is the one
    // just completed and is about to leave EXE.
    assign start_ok = (state_q == IDLE) && bus.exe_start && !done_q
                      && !bus.exe_cancel && op_allowed;

    assign ra_neg = op_is_signed(bus.exe_op) & bus.exe_ra[WIDTH-1];
    assign rb_neg = op_is_signed(bus.exe_op) & bus.exe_rb[WIDTH-1];
    assign abs_ra = ra_neg ? -bus.exe_ra : bus.exe_ra;
    assign abs_rb = rb_neg ? -bus.exe_rb : bus.exe_rb;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .partial_i (partial_q),
        .operand_i (operand_q),
        .op_i      (op_q),
        .partial_o (step_partial)
    );

    assign mul_fix = neg_lo_q ? -partial_q : partial_q;

    // Sign correction. The most-negative / -1 case needs no special path:
    // |a| / 1 = 0x80..0, and negating that value yields itself.
`ifdef MDU_DIV_EN
    always_comb begin
        res_hi = mul_fix[2*WIDTH-1:WIDTH];
        res_lo = mul_fix[WIDTH-1:0];
        if (op_is_div(op_q)) begin
            res_hi = neg_hi_q ? -partial_q[2*WIDTH-1:WIDTH]
                              :  partial_q[2*WIDTH-1:WIDTH];
            // Divide by zero: the remainder path already holds the
            // (sign-restored) dividend; the quotient is forced to all ones.
            if (dz_q) begin
                res_lo = {WIDTH{1'b1}};
            end else begin
                res_lo = neg_lo_q ? -partial_q[WIDTH-1:0]
                                  :  partial_q[WIDTH-1:0];
            end
        end
    end
`else
    logic unused_div;
    assign unused_div = neg_hi_q ^ dz_q;
    assign res_hi = mul_fix[2*WIDTH-1:WIDTH];
    assign res_lo = mul_fix[WIDTH-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        partial_d = partial_q;
        operand_d = operand_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d  = CALC;
                    op_d     = bus.exe_op;
                    cnt_d    = '0;
                    neg_lo_d = ra_neg ^ rb_neg;
                    if (op_is_div(bus.exe_op)) begin
                        operand_d = abs_rb;
                        partial_d = {{WIDTH{1'b0}}, abs_ra};
                        neg_hi_d  = ra_neg;
                        dz_d      = (bus.exe_rb == '0);
                    end else begin
                        operand_d = abs_ra;
                        partial_d = {{WIDTH{1'b0}}, abs_rb};
                        neg_hi_d  = 1'b0;
                        dz_d      = 1'b0;
                    end
                end
            end
            CALC: begin
                if (bus.exe_cancel) begin
                    state_d = IDLE;
                end else begin
                    partial_d = step_partial;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = SIGN;
                    end
                end
            end
            SIGN: begin
                state_d = IDLE;
                // A flush on the write edge discards the result entirely.
                if (!bus.exe_cancel) begin
                    hi_d   = res_hi;
                    lo_d   = res_lo;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            partial_q <= '0;
            operand_q <= '0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
            operand_q <= operand_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // Stall rises combinationally with an accepted start so the instruction
    // is frozen in ID/EXE from the very cycle it arrives.
    assign bus.mdu_stall = start_ok || (state_q == CALC) || (state_q == SIGN);
    assign bus.mdu_done  = done_q;
    assign bus.mdu_hi    = hi_q;
    assign bus.mdu_lo    = lo_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
module tb_exe_muldiv_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    exe_muldiv_unit_if #(.WIDTH(W)) bus ();

    exe_muldiv_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string          name;
        logic [W-1:0]   hi;
        logic [W-1:0]   lo;
        int             done_cyc;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mdu_done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, 64'(bus.mdu_hi), 64'(e.hi));
                    check({e.name, "_lo"}, 64'(bus.mdu_lo), 64'(e.lo));
                    check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
                end
            end
        end
    end

    // Issue one operation (called at posedge+1) and count stall cycles.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input bit hold);
        int st;
        exp_t e;
        st = 0;
        e.name = name; e.hi = exp_hi; e.lo = exp_lo; e.done_cyc = cyc + W + 2;
        sb.push_back(e);
        last_hi = exp_hi;
        last_lo = exp_lo;
        $display("[TB] issue %s op=%b ra=%h rb=%h", name, op, ra, rb);
        bus.exe_op    = op;
        bus.exe_ra    = ra;
        bus.exe_rb    = rb;
        bus.exe_start = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            #1;
            if (bus.mdu_stall === 1'b1) st++;
            @(posedge clk);
            #1;
            if (!hold || i == W + 2) bus.exe_start = 1'b0;
        end
        check({name, "_stall_cycles"}, 64'(st), 64'(W + 2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.exe_start  = 1'b0;
        bus.exe_op     = MDU_MULT;
        bus.exe_ra     = '0;
        bus.exe_rb     = '0;
        bus.exe_cancel = 1'b0;

        #23;
        check("reset_hi",    64'(bus.mdu_hi),    64'(0));
        check("reset_lo",    64'(bus.mdu_lo),    64'(0));
        check("reset_done",  64'(bus.mdu_done),  64'(0));
        check("reset_stall", 64'(bus.mdu_stall), 64'(0));
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;

        run_op("multu_ffff", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_m3x5", MDU_MULT, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);

`ifdef MDU_DIV_EN
        run_op("div_m7_2",   MDU_DIV,  32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0);
        run_op("divu_5_0",   MDU_DIVU, 32'd5, 32'd0,
               32'd5, 32'hFFFF_FFFF, 1'b0);
        run_op("div_m5_0",   MDU_DIV,  32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf",    MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 1'b0);
`else
        // Divider compiled out: divide requests must be ignored.
        begin
            int st;
            st = 0;
            $display("[TB] issue div/divu with divider disabled");
            bus.exe_ra    = 32'd100;
            bus.exe_rb    = 32'd7;
            bus.exe_start = 1'b1;
            for (int i = 0; i < 8; i++) begin
                bus.exe_op = (i < 4) ? MDU_DIV : MDU_DIVU;
                #1;
                if (bus.mdu_stall === 1'b1) st++;
                @(posedge clk);
                #1;
            end
            bus.exe_start = 1'b0;
            check("div_disabled_stall_cycles", 64'(st), 64'(0));
            repeat (40) @(posedge clk);
            #1;
            check("div_disabled_hi", 64'(bus.mdu_hi), 64'(last_hi));
            check("div_disabled_lo", 64'(bus.mdu_lo), 64'(last_lo));
        end
`endif

        // Cancel during CALC (flush seen at the 10th CALC edge).
        $display("[TB] issue mult 3x4 with cancel in CALC");
        bus.exe_op    = MDU_MULT;
        bus.exe_ra    = 32'd3;
        bus.exe_rb    = 32'd4;
        bus.exe_start = 1'b1;
        @(posedge clk);
        #1;
        bus.exe_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.exe_cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.exe_cancel = 1'b0;
        check("cancel_calc_stall", 64'(bus.mdu_stall), 64'(0));
        repeat (40) @(posedge clk);
        #1;
        check("cancel_calc_hi", 64'(bus.mdu_hi), 64'(last_hi));
        check("cancel_calc_lo", 64'(bus.mdu_lo), 64'(last_lo));

        // Cancel landing on the SIGN edge.
        $display("[TB] issue multu 2x3 with cancel on SIGN edge");
        bus.exe_op    = MDU_MULTU;
        bus.exe_ra    = 32'd2;
        bus.exe_rb    = 32'd3;
        bus.exe_start = 1'b1;
        @(posedge clk);
        #1;
        bus.exe_start = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        check("cancel_sign_stall_before", 64'(bus.mdu_stall), 64'(1));
        bus.exe_cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.exe_cancel = 1'b0;
        check("cancel_sign_done", 64'(bus.mdu_done), 64'(0));
        check("cancel_sign_hi", 64'(bus.mdu_hi), 64'(last_hi));
        check("cancel_sign_lo", 64'(bus.mdu_lo), 64'(last_lo));
        check("cancel_sign_stall_after", 64'(bus.mdu_stall), 64'(0));

        // Asynchronous reset in the middle of CALC.
        $display("[TB] issue multu 9x9 then reset during CALC");
        bus.exe_op    = MDU_MULTU;
        bus.exe_ra    = 32'd9;
        bus.exe_rb    = 32'd9;
        bus.exe_start = 1'b1;
        @(posedge clk);
        #1;
        bus.exe_start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        clrn = 1'b0;
        #1;
        check("midreset_hi",    64'(bus.mdu_hi),    64'(0));
        check("midreset_lo",    64'(bus.mdu_lo),    64'(0));
        check("midreset_stall", 64'(bus.mdu_stall), 64'(0));
        check("midreset_done",  64'(bus.mdu_done),  64'(0));
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        run_op("multu_6x7", MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
